// File: rtl/multibyte_seq_if.sv
// Request/result handshake and 8-bit ALU bus for the multi-byte sequencer.
// The slave view belongs to the sequencer; the master view belongs to its requester and ALU.
interface multibyte_seq_if #(
  parameter int unsigned MAXB = 4
);
  localparam int unsigned W = 8 * MAXB;

  logic         start;
  logic [1:0]   op;
  logic [2:0]   len;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         cin;
  logic         ack;
  logic         busy;
  logic         done;
  logic [W-1:0] res;
  logic         co;
  logic         eq;

  logic [3:0]   alu_cmd;
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic         alu_sc_i;
  logic [7:0]   alu_rslt;
  logic         alu_sc_o;
  logic         alu_equal;

  modport slave (
    input  start, op, len, opa, opb, cin, ack, alu_rslt, alu_sc_o, alu_equal,
    output busy, done, res, co, eq, alu_cmd, alu_a, alu_b, alu_sc_i
  );

  modport master (
    output start, op, len, opa, opb, cin, ack, alu_rslt, alu_sc_o, alu_equal,
    input  busy, done, res, co, eq, alu_cmd, alu_a, alu_b, alu_sc_i
  );
endinterface

// File: rtl/multibyte_seq.sv
// Multi-byte ADD/SHL/SHR/CMP sequencer: feeds an external 8-bit ALU one byte per
// cycle, chaining carry/shift bits between bytes and collecting the result.
module multibyte_seq #(
  parameter int unsigned MAXB = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  multibyte_seq_if.slave  bus
);
  localparam int unsigned W = 8 * MAXB;
  localparam logic [2:0] LMAX   = 3'(MAXB);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SHL = 2'b01;
  localparam logic [1:0] OP_SHR = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t       r_state;
  logic [1:0]   r_op;
  logic [2:0]   r_len;
  logic [2:0]   r_idx;
  logic [2:0]   r_cnt;
  logic [W-1:0] r_opa;
  logic [W-1:0] r_opb;
  logic [W-1:0] r_res;
  logic         r_cin;
  logic         r_carry;
  logic         r_co;
  logic         r_eq;
  logic         r_busy;
  logic         r_done;

  logic [2:0]   w_len;
  logic         w_last;
  logic         w_run;
  logic [7:0]   w_a;
  logic [7:0]   w_b;

  // Zero length and anything above MAXB both mean a full-width operation.
  assign w_len  = (bus.len == 3'd0 || bus.len > LMAX) ? LMAX : bus.len;
  assign w_last = (r_cnt == r_len - 3'd1);
  assign w_run  = (r_state == S_RUN);
  assign w_a    = 8'(r_opa >> {r_idx, 3'b000});
  assign w_b    = 8'(r_opb >> {r_idx, 3'b000});

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.res  = r_res;
  assign bus.co   = r_co;
  assign bus.eq   = r_eq;

  // ALU command bus is a decode of registered state only; idle outside RUN.
  always_comb begin
    bus.alu_cmd  = 4'b1111;
    bus.alu_a    = 8'd0;
    bus.alu_b    = 8'd0;
    bus.alu_sc_i = 1'b0;
    if (w_run) begin
      case (r_op)
        OP_ADD:  bus.alu_cmd = 4'b0000;
        OP_SHL:  bus.alu_cmd = 4'b0001;
        OP_SHR:  bus.alu_cmd = 4'b0010;
        default: bus.alu_cmd = 4'b1101;
      endcase
      bus.alu_a    = w_a;
      bus.alu_b    = w_b;
      bus.alu_sc_i = (r_cnt == 3'd0) ? r_cin : r_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_op    <= 2'd0;
      r_len   <= 3'd0;
      r_idx   <= 3'd0;
      r_cnt   <= 3'd0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_cin   <= 1'b0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_eq    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op    <= bus.op;
            r_len   <= w_len;
            r_opa   <= bus.opa;
            r_opb   <= bus.opb;
            r_cin   <= bus.cin;
            r_idx   <= (bus.op == OP_SHR) ? w_len - 3'd1 : 3'd0;
            r_cnt   <= 3'd0;
            r_carry <= 1'b0;
            r_res   <= '0;
            r_co    <= 1'b0;
            r_eq    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // CMP only accumulates the equality flag; res stays cleared.
          if (r_op == OP_CMP) begin
            if (!bus.alu_equal) r_eq <= 1'b0;
          end else begin
            for (int unsigned b = 0; b < MAXB; b++) begin
              if (r_idx == 3'(b)) r_res[8*b +: 8] <= bus.alu_rslt;
            end
          end
          r_carry <= bus.alu_sc_o;
          r_cnt   <= r_cnt + 3'd1;
          r_idx   <= (r_op == OP_SHR) ? r_idx - 3'd1 : r_idx + 3'd1;
          if (w_last) begin
            r_co    <= (r_op == OP_CMP) ? 1'b0 : bus.alu_sc_o;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.ack) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multibyte_seq.sv
// Directed + random bench for multibyte_seq with a behavioural 8-bit ALU and a
// word-level reference model feeding an expected-result queue.
module tb_multibyte_seq;
  localparam int unsigned MAXB = 4;
  localparam int unsigned W    = 8 * MAXB;

  typedef struct {
    logic [63:0] res;
    logic        co;
    logic        eq;
    int          eff;
    logic [3:0]  cmd;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  multibyte_seq_if #(.MAXB(MAXB)) bus ();
  multibyte_seq #(.MAXB(MAXB)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  // Behavioural 8-bit ALU answering in the same cycle.
  always_comb begin
    bus.alu_rslt  = 8'd0;
    bus.alu_sc_o  = 1'b0;
    bus.alu_equal = (bus.alu_a == bus.alu_b);
    case (bus.alu_cmd)
      4'b0000: {bus.alu_sc_o, bus.alu_rslt} = 9'(bus.alu_a) + 9'(bus.alu_b) + 9'(bus.alu_sc_i);
      4'b0001: {bus.alu_sc_o, bus.alu_rslt} = {bus.alu_a, bus.alu_sc_i};
      4'b0010: {bus.alu_rslt, bus.alu_sc_o} = {bus.alu_sc_i, bus.alu_a};
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [2:0] len,
                                 input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t e;
    logic [63:0] m, am, bm, s;
    e.eff = (len == 3'd0 || int'(len) > MAXB) ? MAXB : int'(len);
    m  = (64'd1 << (8 * e.eff)) - 64'd1;
    am = 64'(a) & m;
    bm = 64'(b) & m;
    e.eq = 1'b1;
    case (op)
      2'b00: begin s = am + bm + 64'(cin); e.res = s & m; e.co = s[8*e.eff]; e.cmd = 4'b0000; end
      2'b01: begin s = (am << 1) | 64'(cin); e.res = s & m; e.co = am[8*e.eff-1]; e.cmd = 4'b0001; end
      2'b10: begin e.res = (am >> 1) | (64'(cin) << (8*e.eff-1)); e.co = am[0]; e.cmd = 4'b0010; end
      default: begin e.res = 64'd0; e.co = 1'b0; e.eq = (am == bm); e.cmd = 4'b1101; end
    endcase
    return e;
  endfunction

  // mode 0: plain ack; 1: start pulsed in DONE first; 2: ack and start together.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [2:0] len,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int mode);
    exp_t e;
    int   n;
    int   busy_n;
    sb.push_back(model(op, len, a, b, cin));
    bus.op = op; bus.len = len; bus.opa = a; bus.opb = b; bus.cin = cin; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    e = sb.pop_front();
    check({tag, ":cmd"}, 64'(bus.alu_cmd), 64'(e.cmd));
    n = 1;
    busy_n = 0;
    while (!bus.done && n < 64) begin
      if (bus.busy) busy_n++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, ":done"}, 64'(bus.done), 64'd1);
    check({tag, ":latency"}, 64'(n), 64'(e.eff + 1));
    check({tag, ":busy_cycles"}, 64'(busy_n), 64'(e.eff));
    check({tag, ":res"}, 64'(bus.res), e.res);
    check({tag, ":co"}, 64'(bus.co), 64'(e.co));
    check({tag, ":eq"}, 64'(bus.eq), 64'(e.eq));
    if (mode == 1) begin
      bus.start = 1'b1; bus.opa = ~a;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check({tag, ":start_in_done"}, 64'(bus.busy), 64'd0);
    end
    @(posedge clk); #1;
    check({tag, ":hold_done"}, 64'(bus.done), 64'd1);
    check({tag, ":hold_res"}, 64'(bus.res), e.res);
    bus.ack = 1'b1;
    if (mode == 2) bus.start = 1'b1;
    @(posedge clk); #1;
    bus.ack = 1'b0; bus.start = 1'b0;
    check({tag, ":ack_idle"}, 64'({bus.busy, bus.done}), 64'd0);
    if (mode == 2) begin
      @(posedge clk); #1;
      check({tag, ":ack_start_ignored"}, 64'({bus.busy, bus.done}), 64'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'd0; bus.len = 3'd0; bus.opa = '0; bus.opb = '0;
    bus.cin = 1'b0; bus.ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("reset:outputs", 64'({bus.busy, bus.done, bus.co, bus.eq}), 64'd0);
    check("reset:res", 64'(bus.res), 64'd0);
    check("reset:alu_cmd", 64'({bus.alu_cmd, bus.alu_a, bus.alu_b, bus.alu_sc_i}), 64'h1E0000);

    do_op("add_l4",  2'b00, 3'd4, 32'h000000FF, 32'h00000001, 1'b0, 0);
    do_op("add_l2",  2'b00, 3'd2, 32'hAB12FFFF, 32'h00000001, 1'b0, 0);
    do_op("shl_l4",  2'b01, 3'd4, 32'h80000001, 32'h00000000, 1'b1, 0);
    do_op("shr_l2",  2'b10, 3'd2, 32'h00000001, 32'h00000000, 1'b1, 0);
    do_op("cmp_eq",  2'b11, 3'd3, 32'h12345678, 32'hAB345678, 1'b0, 0);
    do_op("cmp_ne",  2'b11, 3'd3, 32'h12345678, 32'h12335678, 1'b0, 0);
    do_op("add_len0", 2'b00, 3'd0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 0);
    do_op("shr_clamp", 2'b10, 3'd7, 32'h80000003, 32'h00000000, 1'b0, 0);

    // Reset asserted during the second RUN cycle, with start also high.
    bus.op = 2'b00; bus.len = 3'd4; bus.opa = 32'h01020304; bus.opb = 32'h10203040;
    bus.cin = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("midrst:busy_before", 64'(bus.busy), 64'd1);
    reset_n = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1; bus.start = 1'b0;
    check("midrst:flags", 64'({bus.busy, bus.done, bus.co, bus.eq}), 64'd0);
    check("midrst:res", 64'(bus.res), 64'd0);
    check("midrst:alu_cmd", 64'(bus.alu_cmd), 64'hF);
    @(posedge clk); #1;
    check("midrst:start_ignored", 64'(bus.busy), 64'd0);

    do_op("start_in_done", 2'b00, 3'd3, 32'h00123456, 32'h00654321, 1'b0, 1);
    do_op("ack_with_start", 2'b01, 3'd1, 32'h000000C3, 32'h00000000, 1'b0, 2);

    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multibyte_seq.md
MULTIBYTE_SEQ -- requirements
Module: multibyte_seq

Interface
REQ-001 SHALL have parameter MAXB, default 4, meaning the maximum operand width in bytes; the legal range is 1..7.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 SHALL have port op, input, 2 bits: 00 ADD, 01 SHL, 10 SHR, 11 CMP.
REQ-006 SHALL have port len, input, 3 bits: byte count; 0 means MAXB; values above MAXB clamp to MAXB.
REQ-007 SHALL have ports opa and opb, input, 8*MAXB bits each: operands.
REQ-008 SHALL have port cin, input, 1 bit: initial carry or shift-in.
REQ-009 SHALL have ports busy and done, output, 1 bit each: busy is high in RUN; done is high in DONE.
REQ-010 SHALL have ports res (output, 8*MAXB bits), co (output, 1 bit) and eq (output, 1 bit): result, final carry/shift-out, and compare flag.
REQ-011 SHALL have port ack, input, 1 bit: result consumed, sampled only in DONE.
REQ-012 SHALL have port alu_cmd, output, 4 bits: command to the 8-bit ALU.
REQ-013 SHALL have ports alu_a and alu_b (output, 8 bits each) and alu_sc_i (output, 1 bit): ALU operands and carry-in.
REQ-014 SHALL have ports alu_rslt (input, 8 bits), alu_sc_o (input, 1 bit) and alu_equal (input, 1 bit): combinational ALU outputs, valid in the same cycle they are driven.

Function
REQ-015 SHALL implement states IDLE, RUN and DONE, with transitions only on rising clk edges.
REQ-016 In IDLE, SHALL on start=1 latch op, effective length L, opa, opb and cin, clear res to 0, set eq=1, and enter RUN.
REQ-017 In RUN, SHALL process exactly one byte per cycle: drive alu_a and alu_b with byte idx of the latched operands, then at the edge write alu_rslt into res byte idx and store alu_sc_o as the running carry.
REQ-018 SHALL drive alu_sc_i with the latched cin on the first RUN cycle, and with the stored alu_sc_o from the previous byte on every later RUN cycle.
REQ-019 For ADD, SHALL drive alu_cmd=0000 and step idx from 0 up to L-1.
REQ-020 For SHL, SHALL drive alu_cmd=0001 and step idx from 0 up to L-1.
REQ-021 For SHR, SHALL drive alu_cmd=0010 and step idx from L-1 down to 0.
REQ-022 For CMP, SHALL drive alu_cmd=1101, step idx from 0 up to L-1, clear eq to 0 on any cycle where alu_equal=0, and leave res at 0.
REQ-023 SHALL leave res bytes at indices L..MAXB-1 at 0 for every op.
REQ-024 After L RUN cycles, SHALL enter DONE with co equal to the last alu_sc_o; co SHALL be 0 for CMP.
REQ-025 Latency: with start accepted at edge T, busy SHALL be high for edges T+1..T+L and done SHALL first be high after edge T+L.
REQ-026 In DONE, SHALL hold res, co, eq and done stable until ack=1, then return to IDLE at the next edge.
REQ-027 SHALL ignore start while in RUN or DONE.
REQ-028 SHALL ignore ack outside DONE.
REQ-029 When ack=1 in DONE and start=1 on the same cycle, SHALL return to IDLE only; that start is not accepted.
REQ-030 Outside RUN, SHALL drive alu_cmd=1111 (no-op), alu_a=0, alu_b=0 and alu_sc_i=0.
REQ-031 SHALL register res, co, eq, busy and done, with no combinational path from alu_* inputs to them.

Reset
REQ-032 When reset_n=0 at an edge, SHALL go to IDLE from any state, including mid-RUN, with res=0, co=0, eq=0, busy=0, done=0 and idx=0.
REQ-033 SHALL discard any partial result on reset, and SHALL ignore start sampled during that reset cycle.

Verification
REQ-034 Bench SHALL apply ADD, L=4, opa=0x000000FF, opb=0x00000001, cin=0 and check res=0x00000100, co=0, and done first high 5 edges after start.
REQ-035 Bench SHALL apply ADD, len=2, opa=0xAB12FFFF, opb=0x00000001, cin=0 and check res=0x00000000, co=1 (upper bytes ignored and zeroed).
REQ-036 Bench SHALL apply SHL, L=4, opa=0x80000001, cin=1 and check res=0x00000003, co=1.
REQ-037 Bench SHALL apply SHR, len=2, opa=0x00000001, cin=1 and check res=0x00008000, co=1, with the MSB byte processed first.
REQ-038 Bench SHALL apply CMP, len=3, opa=0x12345678 with opb=0xAB345678 and check eq=1; then with opb=0x12335678 and check eq=0; res=0 in both cases.
REQ-039 Bench SHALL drop reset_n for one edge during the 2nd RUN cycle and check IDLE with all outputs 0; then pulse start in DONE and check it is ignored; then hold ack=1 with start=1 in DONE and check exactly one return to IDLE.
